// File: rtl/packet_reader.sv
// packet_reader
// Consumer-side packet engine on the tx side of a ring buffer. It pops a header
// word (payload length in bits [15:0]) and then a payload of len words. Each
// payload word is written to a local memory at base + index. The pop and the
// memory write of a payload word happen in the same cycle, so a memory stall
// also stalls the buffer. Lengths above MAX_LEN are drained without writing
// and flagged as an error. Completion is held on pkt_done_o until done_ack_i.
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   enable_i            allows a new header to be accepted
//   base_addr_i         destination base, captured with the header
//   tx_i / tx_ack_o     buffer has a word / pop strobe
//   data_i              buffer head word
//   mem_we_o, mem_addr_o, mem_data_o, mem_ready_i   memory write port
//   pkt_done_o / done_ack_i   completion handshake
//   pkt_len_o           payload words consumed by the last packet
//   err_o               last packet was dropped or timed out
//   busy_o              engine is not idle
//
// Build option: define PACKET_READER_TIMEOUT_EN to abort a packet after
// TIMEOUT_CYCLES consecutive cycles without a buffer word.
module packet_reader #(
    parameter int DATA_SIZE      = 32,
    parameter int ADDR_SIZE      = 16,
    parameter int MAX_LEN        = 256,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 enable_i,
    input  logic [ADDR_SIZE-1:0] base_addr_i,
    input  logic                 tx_i,
    output logic                 tx_ack_o,
    input  logic [DATA_SIZE-1:0] data_i,
    output logic                 mem_we_o,
    output logic [ADDR_SIZE-1:0] mem_addr_o,
    output logic [DATA_SIZE-1:0] mem_data_o,
    input  logic                 mem_ready_i,
    output logic                 pkt_done_o,
    input  logic                 done_ack_i,
    output logic [15:0]          pkt_len_o,
    output logic                 err_o,
    output logic                 busy_o
);

    localparam logic [15:0] MAX_LEN_L = 16'(MAX_LEN);

    typedef enum logic [1:0] {
        IDLE,
        PAYLOAD,
        DROP,
        DONE
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [15:0]            len;
    logic [15:0]            cnt;
    logic [ADDR_SIZE-1:0]   base;
    logic                   err;
    logic                   hdr_pop;
    logic                   xfer;
    logic                   last;
    logic                   timeout;

    assign last = (cnt == len - 16'd1);

`ifdef PACKET_READER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] idle_cnt;

    // Fires on the TIMEOUT_CYCLES-th consecutive starved cycle.
    assign timeout = (state == PAYLOAD || state == DROP) && !tx_i
                     && (idle_cnt == TIMEOUT_LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idle_cnt <= '0;
        end else if (hdr_pop || xfer) begin
            idle_cnt <= '0;
        end else if ((state == PAYLOAD || state == DROP) && !tx_i) begin
            idle_cnt <= idle_cnt + TW'(1);
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_next = state;
        tx_ack_o   = 1'b0;
        mem_we_o   = 1'b0;
        hdr_pop    = 1'b0;
        xfer       = 1'b0;
        case (state)
            IDLE: begin
                tx_ack_o = enable_i && tx_i;
                hdr_pop  = enable_i && tx_i;
                if (hdr_pop) begin
                    if (data_i[15:0] == 16'd0) begin
                        state_next = DONE;
                    end else if (data_i[15:0] > MAX_LEN_L) begin
                        state_next = DROP;
                    end else begin
                        state_next = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                // Write and pop are one event: a memory stall leaves the word
                // at the buffer head, so address and data stay stable.
                mem_we_o = tx_i;
                tx_ack_o = tx_i && mem_ready_i;
                xfer     = tx_i && mem_ready_i;
                if ((xfer && last) || timeout) begin
                    state_next = DONE;
                end
            end
            DROP: begin
                tx_ack_o = tx_i;
                xfer     = tx_i;
                if ((xfer && last) || timeout) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (done_ack_i) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        // Pops and writes stop in the very cycle reset is asserted so that no
        // buffer word is lost while the state is being cleared.
        if (rst_i) begin
            tx_ack_o = 1'b0;
            mem_we_o = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            len   <= '0;
            cnt   <= '0;
            base  <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_next;
            if (hdr_pop) begin
                len  <= data_i[15:0];
                base <= base_addr_i;
                cnt  <= '0;
                err  <= (data_i[15:0] > MAX_LEN_L);
            end else if (xfer) begin
                cnt <= cnt + 16'd1;
            end
            if (timeout) begin
                err <= 1'b1;
            end
            if (state == DONE && done_ack_i) begin
                err <= 1'b0;
            end
        end
    end

    // Address arithmetic wraps naturally at ADDR_SIZE bits.
    assign mem_addr_o = base + ADDR_SIZE'(cnt);
    assign mem_data_o = data_i;
    assign pkt_done_o = (state == DONE);
    assign pkt_len_o  = cnt;
    assign err_o      = err;
    assign busy_o     = (state != IDLE);

endmodule

// File: tb/tb_packet_reader.sv
// Self-checking bench for packet_reader: a queue models the ring buffer,
// expected memory writes are queued as packets are built and compared as the
// DUT writes them. Define PACKET_READER_TIMEOUT_EN to include the starvation case.
module tb_packet_reader;

    localparam int DW = 32;
    localparam int AW = 16;
    localparam int ML = 8;
    localparam int TO = 8;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic          clk;
    logic          rst_i;
    logic          enable_i;
    logic [AW-1:0] base_addr_i;
    logic          tx_i;
    logic          tx_ack_o;
    logic [DW-1:0] data_i;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_data_o;
    logic          mem_ready_i;
    logic          pkt_done_o;
    logic          done_ack_i;
    logic [15:0]   pkt_len_o;
    logic          err_o;
    logic          busy_o;

    logic [DW-1:0] buf_q[$];
    wr_t           exp_q[$];
    int            n_chk = 0;
    int            n_pass = 0;
    int            cyc = 0;
    int            hdr_cyc = 0;
    int            done_cyc = 0;
    int            wr_cnt = 0;
    bit            done_seen = 0;
    bit            pop_flag = 0;
    bit            stall_mode = 0;

    packet_reader #(
        .DATA_SIZE(DW), .ADDR_SIZE(AW), .MAX_LEN(ML), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i), .base_addr_i(base_addr_i),
        .tx_i(tx_i), .tx_ack_o(tx_ack_o), .data_i(data_i),
        .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_ready_i(mem_ready_i), .pkt_done_o(pkt_done_o), .done_ack_i(done_ack_i),
        .pkt_len_o(pkt_len_o), .err_o(err_o), .busy_o(busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, got, want);
    endtask

    // Buffer model: pops the head after an edge where tx_i && tx_ack_o held.
    initial begin
        tx_i = 1'b0;
        data_i = '0;
        mem_ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (pop_flag && buf_q.size() > 0) void'(buf_q.pop_front());
            mem_ready_i = stall_mode ? ~mem_ready_i : 1'b1;
            tx_i = (buf_q.size() > 0);
            data_i = (buf_q.size() > 0) ? buf_q[0] : '0;
        end
    end

    // Monitor: samples on the falling edge, scoreboards memory writes.
    initial begin
        bit            stalled = 0;
        logic [AW-1:0] held_a = '0;
        logic [DW-1:0] held_d = '0;
        wr_t           e;
        forever begin
            @(negedge clk);
            cyc++;
            pop_flag = tx_i && tx_ack_o;
            if (!busy_o && pop_flag) hdr_cyc = cyc;
            if (pkt_done_o && !done_seen) begin
                done_seen = 1;
                done_cyc = cyc;
            end
            if (stalled && mem_we_o) begin
                chk("stall_hold_addr", mem_addr_o, held_a);
                chk("stall_hold_data", mem_data_o, held_d);
            end
            if (mem_we_o && !mem_ready_i) chk("stall_no_pop", tx_ack_o, 0);
            stalled = mem_we_o && !mem_ready_i;
            held_a = mem_addr_o;
            held_d = mem_data_o;
            if (mem_we_o && mem_ready_i) begin
                wr_cnt++;
                chk("wr_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("wr_addr", mem_addr_o, e.addr);
                    chk("wr_data", mem_data_o, e.data);
                end
            end
        end
    end

    task automatic send(input int len, input int nwords, input logic [AW-1:0] base,
                        input bit drop, input logic [15:0] hi);
        logic [DW-1:0] w;
        wr_t           e;
        base_addr_i = base;
        done_seen = 0;
        buf_q.push_back({hi, 16'(len)});
        for (int i = 0; i < nwords; i++) begin
            w = $urandom;
            buf_q.push_back(w);
            if (!drop) begin
                e.addr = AW'(int'(base) + i);
                e.data = w;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 200; i++) begin
            if (done_seen) break;
            @(negedge clk);
            #1;
        end
        chk({tag, "_done"}, done_seen, 1);
    endtask

    task automatic ack();
        @(posedge clk);
        #1 done_ack_i = 1'b1;
        @(posedge clk);
        #1 done_ack_i = 1'b0;
        chk("ack_busy", busy_o, 0);
        chk("ack_err", err_o, 0);
        chk("ack_done", pkt_done_o, 0);
    endtask

    initial begin
        int w0;
        rst_i = 1'b1;
        enable_i = 1'b1;
        base_addr_i = '0;
        done_ack_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_tx_ack", tx_ack_o, 0);
        chk("rst_mem_we", mem_we_o, 0);
        chk("rst_mem_addr", mem_addr_o, 0);
        chk("rst_done", pkt_done_o, 0);
        chk("rst_len", pkt_len_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_busy", busy_o, 0);
        @(posedge clk);
        #1 rst_i = 1'b0;

        // Basic packet, junk in header upper bits.
        send(4, 4, 16'h0010, 0, 16'hABCD);
        wait_done("basic");
        chk("basic_lat", done_cyc - hdr_cyc, 5);
        chk("basic_len", pkt_len_o, 4);
        chk("basic_err", err_o, 0);
        chk("basic_all_wr", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #1 chk("basic_done_hold", pkt_done_o, 1);
        ack();

        // Alternating memory stalls.
        stall_mode = 1;
        send(4, 4, 16'h0010, 0, 16'h0000);
        wait_done("stall");
        chk("stall_len", pkt_len_o, 4);
        chk("stall_all_wr", exp_q.size(), 0);
        stall_mode = 0;
        ack();

        // Empty packet.
        send(0, 0, 16'h0020, 0, 16'h0000);
        wait_done("zero");
        chk("zero_lat", done_cyc - hdr_cyc, 1);
        chk("zero_len", pkt_len_o, 0);
        chk("zero_err", err_o, 0);
        ack();

        // Largest accepted length.
        send(ML, ML, 16'h0040, 0, 16'h0000);
        wait_done("max");
        chk("max_lat", done_cyc - hdr_cyc, ML + 1);
        chk("max_len", pkt_len_o, ML);
        chk("max_err", err_o, 0);
        chk("max_all_wr", exp_q.size(), 0);
        ack();

        // Oversize packet is drained without writes.
        send(ML + 1, ML + 1, 16'h0080, 1, 16'h0000);
        wait_done("drop");
        chk("drop_lat", done_cyc - hdr_cyc, ML + 2);
        chk("drop_len", pkt_len_o, ML + 1);
        chk("drop_err", err_o, 1);
        chk("drop_drained", buf_q.size(), 0);
        ack();

        // Address wrap.
        send(4, 4, 16'hFFFE, 0, 16'h0000);
        wait_done("wrap");
        chk("wrap_len", pkt_len_o, 4);
        chk("wrap_all_wr", exp_q.size(), 0);
        ack();

        // Reset after two of six payload words.
        w0 = wr_cnt;
        send(6, 6, 16'h0100, 0, 16'h0000);
        for (int i = 0; i < 100; i++) begin
            if (wr_cnt >= w0 + 2) break;
            @(negedge clk);
            #1;
        end
        chk("rst_mid_two_wr", wr_cnt - w0, 2);
        @(posedge clk);
        #1 rst_i = 1'b1;
        enable_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_mid_busy", busy_o, 0);
        chk("rst_mid_tx_ack", tx_ack_o, 0);
        chk("rst_mid_done", pkt_done_o, 0);
        @(posedge clk);
        #1 rst_i = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        #1;
        chk("en_low_no_pop", tx_ack_o, 0);
        chk("rst_mid_wr_left", exp_q.size(), 4);
        chk("rst_mid_buf_left", buf_q.size(), 4);
        buf_q.delete();
        exp_q.delete();
        enable_i = 1'b1;
        repeat (2) @(posedge clk);

`ifdef PACKET_READER_TIMEOUT_EN
        // Buffer starves after two of five words.
        send(5, 2, 16'h0200, 0, 16'h0000);
        wait_done("tmo");
        chk("tmo_lat", done_cyc - hdr_cyc, 3 + TO);
        chk("tmo_len", pkt_len_o, 2);
        chk("tmo_err", err_o, 1);
        chk("tmo_all_wr", exp_q.size(), 0);
        ack();
`endif

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

endmodule
